// File: rtl/chnlnk_frame_rx.sv
// chnlnk_frame_rx -- receive-side deframer for the DCFEB channel-link frame stream.
//
// Hunts for a K-marked header word, forwards SAMP_MAX payload words tagged with their
// in-frame index, then checks the trailing CRC-16 word. Truncated frames (early header
// or idle timeout) and CRC mismatches are flagged and counted.
//
// Ports:
//   CLK       system clock
//   RST_N     synchronous active-low reset
//   RX_DATA   received link word
//   RX_K      header marker, qualifies RX_DATA as a header word
//   RX_VALID  RX_DATA/RX_K valid this cycle (low = stall)
//   SAMP_MAX  payload words per frame, latched at header
//   CNT_CLR   synchronous clear of FRM_CNT and ERR_CNT
//   HDR_WORD  last accepted header word
//   DOUT      payload word
//   DOUT_WE   DOUT valid strobe
//   SEQ       sequence index of DOUT
//   SOF       with first payload DOUT_WE, or with the header when SAMP_MAX=0
//   FRM_DONE  pulse: CRC word consumed, frame complete
//   CRC_ERR   pulse with FRM_DONE when the CRC mismatches
//   LEN_ERR   pulse: frame truncated (early header or timeout)
//   FRM_CNT   good-frame count (wraps)
//   ERR_CNT   error count (saturates)
//   STATE     FSM state: 0 HUNT, 1 PLD, 2 CRCW
module chnlnk_frame_rx #(
  parameter int unsigned DW  = 16,
  parameter int unsigned TMO = 255
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] RX_DATA,
  input  logic          RX_K,
  input  logic          RX_VALID,
  input  logic [6:0]    SAMP_MAX,
  input  logic          CNT_CLR,
  output logic [DW-1:0] HDR_WORD,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_WE,
  output logic [6:0]    SEQ,
  output logic          SOF,
  output logic          FRM_DONE,
  output logic          CRC_ERR,
  output logic          LEN_ERR,
  output logic [15:0]   FRM_CNT,
  output logic [7:0]    ERR_CNT,
  output logic [1:0]    STATE
);

  // Idle counter only needs to reach TMO-1; the TMO-th idle cycle fires the abort.
  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TmoLast = (TMO == 0) ? '0 : TW'(TMO - 1);

  typedef enum logic [1:0] {
    StHunt = 2'd0,
    StPld  = 2'd1,
    StCrcw = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   hdr_q, hdr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_we_q, dout_we_d;
  logic [6:0]      seq_out_q, seq_out_d;
  logic            sof_q, sof_d;
  logic            frm_done_q, frm_done_d;
  logic            crc_err_q, crc_err_d;
  logic            len_err_q, len_err_d;
  logic [15:0]     frm_cnt_q, frm_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [6:0]      smax_q, smax_d;
  logic [6:0]      seq_q, seq_d;
  logic [15:0]     crc_q, crc_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            start_frame;

  // CRC-16 CCITT (poly 0x1021), one bit per step, MSB of the word first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [DW-1:0] word);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[15] ^ word[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    dout_d      = dout_q;
    seq_out_d   = seq_out_q;
    smax_d      = smax_q;
    seq_d       = seq_q;
    crc_d       = crc_q;
    idle_d      = idle_q;
    frm_cnt_d   = frm_cnt_q;
    err_cnt_d   = err_cnt_q;
    dout_we_d   = 1'b0;
    sof_d       = 1'b0;
    frm_done_d  = 1'b0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    start_frame = 1'b0;

    if (RX_VALID) begin
      idle_d = '0;
      case (state_q)
        StHunt: begin
          // Non-K words while hunting are line noise between frames: dropped silently.
          if (RX_K) start_frame = 1'b1;
        end
        StPld: begin
          if (RX_K) begin
            len_err_d   = 1'b1;
            start_frame = 1'b1;
          end else begin
            dout_d    = RX_DATA;
            dout_we_d = 1'b1;
            seq_out_d = seq_q;
            sof_d     = (seq_q == 7'd0);
            crc_d     = crc_step(crc_q, RX_DATA);
            if (seq_q == smax_q - 7'd1) begin
              state_d = StCrcw;
            end else begin
              seq_d = seq_q + 7'd1;
            end
          end
        end
        StCrcw: begin
          if (RX_K) begin
            len_err_d   = 1'b1;
            start_frame = 1'b1;
          end else begin
            frm_done_d = 1'b1;
            crc_err_d  = (RX_DATA != DW'(crc_q));
            state_d    = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase

      // A header always restarts framing, whatever state it interrupted.
      if (start_frame) begin
        hdr_d  = RX_DATA;
        smax_d = SAMP_MAX;
        crc_d  = crc_step(16'hFFFF, RX_DATA);
        seq_d  = 7'd0;
        if (SAMP_MAX == 7'd0) begin
          state_d = StCrcw;
          sof_d   = 1'b1;
        end else begin
          state_d = StPld;
        end
      end
    end else if ((TMO != 0) && (state_q != StHunt)) begin
      if (idle_q == TmoLast) begin
        len_err_d = 1'b1;
        state_d   = StHunt;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end

    // Counters advance on the same edge that raises the corresponding pulse.
    if (CNT_CLR) begin
      frm_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (frm_done_d && !crc_err_d) frm_cnt_d = frm_cnt_q + 16'd1;
      if ((crc_err_d || len_err_d) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StHunt;
      hdr_q      <= '0;
      dout_q     <= '0;
      dout_we_q  <= 1'b0;
      seq_out_q  <= '0;
      sof_q      <= 1'b0;
      frm_done_q <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      frm_cnt_q  <= '0;
      err_cnt_q  <= '0;
      smax_q     <= '0;
      seq_q      <= '0;
      crc_q      <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      dout_q     <= dout_d;
      dout_we_q  <= dout_we_d;
      seq_out_q  <= seq_out_d;
      sof_q      <= sof_d;
      frm_done_q <= frm_done_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
      frm_cnt_q  <= frm_cnt_d;
      err_cnt_q  <= err_cnt_d;
      smax_q     <= smax_d;
      seq_q      <= seq_d;
      crc_q      <= crc_d;
      idle_q     <= idle_d;
    end
  end

  assign HDR_WORD = hdr_q;
  assign DOUT     = dout_q;
  assign DOUT_WE  = dout_we_q;
  assign SEQ      = seq_out_q;
  assign SOF      = sof_q;
  assign FRM_DONE = frm_done_q;
  assign CRC_ERR  = crc_err_q;
  assign LEN_ERR  = len_err_q;
  assign FRM_CNT  = frm_cnt_q;
  assign ERR_CNT  = err_cnt_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_chnlnk_frame_rx.sv
// Self-checking bench for chnlnk_frame_rx (DW=16, TMO=4).
module tb_chnlnk_frame_rx;

  localparam int TMO_TB = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] RX_DATA;
  logic        RX_K;
  logic        RX_VALID;
  logic [6:0]  SAMP_MAX;
  logic        CNT_CLR;
  logic [15:0] HDR_WORD;
  logic [15:0] DOUT;
  logic        DOUT_WE;
  logic [6:0]  SEQ;
  logic        SOF;
  logic        FRM_DONE;
  logic        CRC_ERR;
  logic        LEN_ERR;
  logic [15:0] FRM_CNT;
  logic [7:0]  ERR_CNT;
  logic [1:0]  STATE;

  chnlnk_frame_rx #(.DW(16), .TMO(TMO_TB)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_K(RX_K), .RX_VALID(RX_VALID),
    .SAMP_MAX(SAMP_MAX), .CNT_CLR(CNT_CLR), .HDR_WORD(HDR_WORD), .DOUT(DOUT),
    .DOUT_WE(DOUT_WE), .SEQ(SEQ), .SOF(SOF), .FRM_DONE(FRM_DONE), .CRC_ERR(CRC_ERR),
    .LEN_ERR(LEN_ERR), .FRM_CNT(FRM_CNT), .ERR_CNT(ERR_CNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] d;
    logic [6:0]  seq;
    logic        sof;
  } dexp_t;

  dexp_t      dq[$];   // expected payload outputs
  logic [2:0] eq[$];   // expected {frm_done, crc_err, len_err} events

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_state = 0;
  int          m_seq = 0;
  int          m_smax = 0;
  int          m_idle = 0;
  logic [15:0] m_crc = 16'h0;
  logic [15:0] m_hdr = 16'h0;
  int          exp_frm = 0;
  int          exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-at-a-time CRC-CCITT: XOR the word in, then 16 polynomial-division shifts.
  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c ^ w;
    for (int i = 0; i < 16; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] frame_crc(input logic [15:0] hdr, input logic [15:0] base,
                                            input int n);
    logic [15:0] c;
    c = crc16(16'hFFFF, hdr);
    for (int i = 0; i < n; i++) c = crc16(c, base + 16'(i));
    return c;
  endfunction

  task automatic count(input logic ok, input logic err);
    if (ok) exp_frm = (exp_frm + 1) & 32'hFFFF;
    if (err && exp_err < 255) exp_err++;
    if (CNT_CLR) begin
      exp_frm = 0;
      exp_err = 0;
    end
  endtask

  task automatic put(input logic k, input logic [15:0] d);
    logic ok, err;
    ok  = 1'b0;
    err = 1'b0;
    if (k) begin
      if (m_state != 0) begin
        eq.push_back(3'b001);
        err = 1'b1;
      end
      m_hdr   = d;
      m_smax  = int'(SAMP_MAX);
      m_crc   = crc16(16'hFFFF, d);
      m_seq   = 0;
      m_state = (SAMP_MAX == 0) ? 2 : 1;
    end else if (m_state == 1) begin
      dq.push_back('{d: d, seq: 7'(m_seq), sof: (m_seq == 0)});
      m_crc = crc16(m_crc, d);
      m_seq++;
      if (m_seq == m_smax) m_state = 2;
    end else if (m_state == 2) begin
      eq.push_back({1'b1, d != m_crc, 1'b0});
      ok      = (d == m_crc);
      err     = (d != m_crc);
      m_state = 0;
    end
    m_idle = 0;
    count(ok, err);
    RX_VALID = 1'b1;
    RX_K     = k;
    RX_DATA  = d;
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
    RX_K     = 1'b0;
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      logic err;
      err = 1'b0;
      if (m_state != 0) begin
        m_idle++;
        if (m_idle == TMO_TB) begin
          eq.push_back(3'b001);
          err     = 1'b1;
          m_state = 0;
          m_idle  = 0;
        end
      end
      count(1'b0, err);
      RX_VALID = 1'b0;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] hdr, input logic [15:0] base, input int n,
                            input logic [15:0] crc_xor);
    put(1'b1, hdr);
    for (int i = 0; i < n; i++) put(1'b0, base + 16'(i));
    put(1'b0, frame_crc(hdr, base, n) ^ crc_xor);
  endtask

  // Scoreboard: pop expectations as the DUT produces output.
  always @(negedge CLK) begin
    dexp_t      e;
    logic [2:0] ev;
    if (DOUT_WE) begin
      if (dq.size() == 0) chk("dout_spurious", 32'(DOUT_WE), 32'd0);
      else begin
        e = dq.pop_front();
        chk("dout", 32'(DOUT), 32'(e.d));
        chk("seq", 32'(SEQ), 32'(e.seq));
        chk("sof", 32'(SOF), 32'(e.sof));
      end
    end
    if (FRM_DONE || CRC_ERR || LEN_ERR) begin
      if (eq.size() == 0) chk("event_spurious", {29'd0, FRM_DONE, CRC_ERR, LEN_ERR}, 32'd0);
      else begin
        ev = eq.pop_front();
        chk("event", {29'd0, FRM_DONE, CRC_ERR, LEN_ERR}, 32'(ev));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N    = 1'b0;
    RX_DATA  = 16'h0;
    RX_K     = 1'b0;
    RX_VALID = 1'b0;
    SAMP_MAX = 7'd8;
    CNT_CLR  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_hdr", 32'(HDR_WORD), 32'd0);
    chk("rst_frm_cnt", 32'(FRM_CNT), 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("rst_seq", 32'(SEQ), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // 1: good frame
    send_frame(16'hA5A5, 16'h0000, 8, 16'h0000);
    chk("t1_frm_cnt", 32'(FRM_CNT), 32'd1);
    chk("t1_hdr", 32'(HDR_WORD), 32'hA5A5);
    chk("t1_state", 32'(STATE), 32'd0);

    // 2: CRC bit 0 flipped
    send_frame(16'hA5A5, 16'h0000, 8, 16'h0001);
    chk("t2_frm_cnt", 32'(FRM_CNT), 32'd1);
    chk("t2_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("t2_state", 32'(STATE), 32'd0);

    // 3: header arrives at SEQ=3, then completes as a good frame
    put(1'b1, 16'h1111);
    for (int i = 0; i < 3; i++) put(1'b0, 16'h0100 + 16'(i));
    send_frame(16'h2222, 16'h0200, 8, 16'h0000);
    chk("t3_err_cnt", 32'(ERR_CNT), 32'd2);
    chk("t3_frm_cnt", 32'(FRM_CNT), 32'd2);
    chk("t3_hdr", 32'(HDR_WORD), 32'h2222);

    // 4: timeout after 4 idle cycles; 3 idle cycles is tolerated
    put(1'b1, 16'h3333);
    for (int i = 0; i < 3; i++) put(1'b0, 16'h0300 + 16'(i));
    stall(3);
    chk("t4_len_err_early", 32'(LEN_ERR), 32'd0);
    chk("t4_state_pld", 32'(STATE), 32'd1);
    stall(1);
    chk("t4_len_err", 32'(LEN_ERR), 32'd1);
    chk("t4_state_hunt", 32'(STATE), 32'd0);
    chk("t4_err_cnt", 32'(ERR_CNT), 32'd3);
    put(1'b1, 16'h4444);
    for (int i = 0; i < 3; i++) put(1'b0, 16'h0400 + 16'(i));
    stall(3);
    for (int i = 3; i < 8; i++) put(1'b0, 16'h0400 + 16'(i));
    put(1'b0, frame_crc(16'h4444, 16'h0400, 8));
    chk("t4_frm_cnt", 32'(FRM_CNT), 32'd3);
    chk("t4_err_cnt2", 32'(ERR_CNT), 32'd3);

    // 5: empty frame, then noise in HUNT
    SAMP_MAX = 7'd0;
    put(1'b1, 16'h1234);
    chk("t5_sof", 32'(SOF), 32'd1);
    chk("t5_dout_we", 32'(DOUT_WE), 32'd0);
    chk("t5_state", 32'(STATE), 32'd2);
    put(1'b0, crc16(16'hFFFF, 16'h1234));
    chk("t5_frm_cnt", 32'(FRM_CNT), 32'd4);
    for (int i = 0; i < 3; i++) put(1'b0, 16'hBEEF);
    chk("t5_noise_err", 32'(ERR_CNT), 32'd3);
    chk("t5_noise_state", 32'(STATE), 32'd0);

    // 6: saturation, clear priority, reset mid-frame
    SAMP_MAX = 7'd8;
    put(1'b1, 16'h5000);
    for (int i = 1; i <= 256; i++) put(1'b1, 16'h5000 + 16'(i));
    chk("t6_sat", 32'(ERR_CNT), 32'd255);
    CNT_CLR = 1'b1;
    put(1'b1, 16'h6000);
    CNT_CLR = 1'b0;
    chk("t6_clr_err", 32'(ERR_CNT), 32'd0);
    chk("t6_clr_frm", 32'(FRM_CNT), 32'd0);
    put(1'b0, 16'h0600);
    put(1'b0, 16'h0601);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    m_state = 0;
    m_idle  = 0;
    chk("t6_rst_outs", {HDR_WORD, DOUT}, 32'd0);
    chk("t6_rst_flags", {22'd0, DOUT_WE, SEQ, SOF, FRM_DONE, CRC_ERR, LEN_ERR}, 32'd0);
    chk("t6_rst_cnts", {FRM_CNT, ERR_CNT, 6'd0, STATE}, 32'd0);
    RST_N = 1'b1;
    put(1'b0, 16'h0055);
    chk("t6_post_rst_we", 32'(DOUT_WE), 32'd0);
    chk("t6_post_rst_state", 32'(STATE), 32'd0);
    send_frame(16'h7777, 16'h0700, 8, 16'h0000);
    chk("t6_frm_cnt", 32'(FRM_CNT), 32'd1);
    chk("t6_model_frm", 32'(FRM_CNT), 32'(exp_frm));
    chk("t6_model_err", 32'(ERR_CNT), 32'(exp_err));
    chk("t6_model_hdr", 32'(HDR_WORD), 32'(m_hdr));

    repeat (3) @(posedge CLK);
    #1;
    chk("dq_empty", 32'(dq.size()), 32'd0);
    chk("eq_empty", 32'(eq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chnlnk_frame_rx.md
Name: chnlnk_frame_rx

Overview:
- Receive-side deframer for the DCFEB channel-link frame stream, the counterpart of the channel-link frame transmitter.
- Hunts for a header word and latches it. Strips and forwards SAMP_MAX payload words, tagging each with its in-frame sequence index.
- Checks the trailing CRC word, flags length, CRC and timeout errors, and keeps frame and error counters for slow control.
- Sits between the link word recovery logic and the downstream sample FIFO or readback path.

Parameters:
DW, 16, link word and payload width
TMO, 255, max idle cycles allowed mid-frame before abort (0 disables timeout)

Ports:
CLK  in  1  system clock
RST_N  in  1  synchronous active-low reset
RX_DATA  in  DW  received link word
RX_K  in  1  header marker, qualifies RX_DATA as header word
RX_VALID  in  1  RX_DATA/RX_K valid this cycle
SAMP_MAX  in  7  payload words per frame, latched at header
CNT_CLR  in  1  synchronous clear of FRM_CNT and ERR_CNT
HDR_WORD  out  DW  last accepted header word
DOUT  out  DW  payload word
DOUT_WE  out  1  DOUT valid strobe
SEQ  out  7  sequence index of DOUT, 0..SAMP_MAX-1
SOF  out  1  with first payload DOUT_WE, or with header when SAMP_MAX=0
FRM_DONE  out  1  pulse: CRC word consumed, frame complete
CRC_ERR  out  1  pulse with FRM_DONE when CRC mismatches
LEN_ERR  out  1  pulse: frame truncated (early header or timeout)
FRM_CNT  out  16  good-frame count
ERR_CNT  out  8  error count
STATE  out  2  FSM state: 0 HUNT, 1 PLD, 2 CRCW

Behaviour:
- Reset (RST_N=0 at CLK edge): STATE=HUNT; all outputs 0, including HDR_WORD, SEQ, counters and CRC register.
- All outputs are registered: 1-cycle latency from accepted input word to output.
- A word is accepted only when RX_VALID=1; RX_VALID=0 cycles are stalls and hold all state except the timeout counter.
- CRC:
  - CRC-16 CCITT, polynomial 0x1021, init 0xFFFF, 16 bits per accepted word, MSB first.
  - Covers the header word and all payload words; the CRC word itself is excluded.
- HUNT:
  - Valid & K: latch HDR_WORD and smax=SAMP_MAX; crc=f(0xFFFF, word); seq=0.
  - Then go to PLD, or to CRCW if SAMP_MAX=0.
  - Valid & !K: discard silently, no error.
- PLD:
  - Valid & !K: DOUT=word; DOUT_WE=1; SEQ=seq; SOF=(seq==0); crc update.
  - If seq==smax-1, go to CRCW; else seq+1.
  - Valid & K: LEN_ERR pulse; restart as if accepting a header in HUNT (new HDR_WORD, crc reinit, seq=0), stay in or re-enter PLD.
- CRCW:
  - Valid & !K: FRM_DONE=1; CRC_ERR=(word!=crc); go to HUNT.
  - Valid & K: LEN_ERR pulse; restart with the new header.
- Timeout:
  - In PLD/CRCW, an idle counter increments each cycle with RX_VALID=0 and clears on an accepted word.
  - Reaching TMO raises a LEN_ERR pulse and returns to HUNT.
  - Inactive when TMO=0.
- Counters:
  - FRM_CNT increments on FRM_DONE with no CRC error and wraps 0xFFFF->0.
  - ERR_CNT increments on each CRC_ERR or LEN_ERR pulse and saturates at 255.
  - CNT_CLR has priority over increment in the same cycle.
- Pulse outputs (DOUT_WE, SOF, FRM_DONE, CRC_ERR, LEN_ERR) are single-cycle per event.
- SAMP_MAX changes mid-frame have no effect until the next header.
- Reset mid-frame aborts with no error pulse; the next frame requires a new header.

Test Plan:
1. Reset, SAMP_MAX=8; header 0xA5A5 followed by 8 payload words 0x0000..0x0007 and the correct CRC, RX_VALID continuous -> DOUT_WE 8 cycles with SEQ 0..7, SOF on SEQ=0, FRM_DONE 1 cycle after the CRC word, CRC_ERR=0, FRM_CNT=1, HDR_WORD=0xA5A5.
2. Same frame with CRC bit 0 flipped -> FRM_DONE=1 and CRC_ERR=1 same cycle, FRM_CNT unchanged, ERR_CNT=1, STATE=HUNT.
3. Header at SEQ=3 of an 8-word frame, followed by a complete good frame -> LEN_ERR pulse, ERR_CNT+1, second frame SEQ 0..7 and FRM_DONE, FRM_CNT+1.
4. TMO=4; stall RX_VALID low for 4 cycles after payload word 2 -> LEN_ERR on the 4th idle cycle, STATE=HUNT; a stall of 3 cycles instead completes the frame normally.
5. SAMP_MAX=0; header then CRC=f(header) -> no DOUT_WE, FRM_DONE, FRM_CNT+1. Non-K words in HUNT -> ignored, no error.
6. Force 256 errors -> ERR_CNT holds at 255; CNT_CLR with a coincident error -> ERR_CNT=0. Assert RST_N=0 mid-frame -> all outputs 0 the next cycle.
